// File: rtl/sfifo_mp.sv
// sfifo_mp: circular FIFO with two write lanes and two read lanes, occupancy count, watermark and flush.
// Define SFIFO_MP_ERR_EN to enable the sticky protocol-error flag o_err.
module sfifo_mp #(
  parameter int FW       = 64,
  parameter int DW       = 8,
  parameter int AF_LEVEL = FW - 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic [1:0]      i_wr_en,
  input  logic [2*DW-1:0] i_wr_data,
  output logic            o_wr_rdy,
  input  logic [1:0]      i_rd,
  output logic [1:0]      o_rd_valid,
  output logic [2*DW-1:0] o_rd_data,
  output logic [$clog2(FW):0] o_count,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_afull,
  output logic            o_err
);
  localparam int AW = $clog2(FW);
  logic [AW:0]    rd_ptr, wr_ptr, free;
  logic [AW-1:0]  wa0, wa1, ra0, ra1;
  logic [1:0]     nw, nr;
  logic           wr_acc, pop0, pop1;
  logic [DW-1:0]  mem [FW];
  assign o_count    = wr_ptr - rd_ptr;
  assign free       = (AW+1)'(FW) - o_count;
  assign nw         = {1'b0, i_wr_en[0]} + {1'b0, i_wr_en[1]};
  // Space is judged on pre-read occupancy; same-cycle pops never make room.
  assign o_wr_rdy   = free >= (AW+1)'(nw);
  assign wr_acc     = o_wr_rdy && |i_wr_en && !i_flush;
  assign o_rd_valid = {o_count >= (AW+1)'(2), o_count != '0};
  assign pop0       = i_rd[0] && o_rd_valid[0];
  assign pop1       = &i_rd && o_rd_valid[1];
  assign nr         = {1'b0, pop0} + {1'b0, pop1};
  assign o_empty    = o_count == '0;
  assign o_full     = o_count == (AW+1)'(FW);
  assign o_afull    = o_count >= (AW+1)'(AF_LEVEL);
  assign wa0        = wr_ptr[AW-1:0];
  assign wa1        = wa0 + AW'(1);
  assign ra0        = rd_ptr[AW-1:0];
  assign ra1        = ra0 + AW'(1);
  assign o_rd_data  = {mem[ra1], mem[ra0]};
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (i_flush) rd_ptr <= wr_ptr;
    else begin
      rd_ptr <= rd_ptr + (AW+1)'(nr);
      if (wr_acc) wr_ptr <= wr_ptr + (AW+1)'(nw);
    end
  // Accepted lanes are compacted: a lone lane 1 write lands at wr_ptr.
  always_ff @(posedge i_clk)
    if (wr_acc) begin
      mem[wa0] <= i_wr_en[0] ? i_wr_data[DW-1:0] : i_wr_data[2*DW-1:DW];
      if (&i_wr_en) mem[wa1] <= i_wr_data[2*DW-1:DW];
    end
`ifdef SFIFO_MP_ERR_EN
  logic err;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) err <= 1'b0;
    else if ((|i_wr_en && !o_wr_rdy) || (i_rd[1] && !i_rd[0]) || |(i_rd & ~o_rd_valid)) err <= 1'b1;
  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif
endmodule
